// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-side signals of the arbiter.
// The master modport is the requester/RAM-model side; the slave modport is the arbiter.
interface ram_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic        datomic;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport master (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access,
// with data priority, fetch anti-starvation, timeout and the LL/SC link register.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          CLK,
  input logic          RST,
  ram_arbiter_if.slave bus
);
  localparam int unsigned CNT_W     = $clog2(TIMEOUT);
  localparam logic [1:0]  RS_ACCESS = 2'b10;
  localparam logic [1:0]  RS_ERROR  = 2'b11;

  typedef enum logic [1:0] {IDLE, DSERV, ISERV, SCFAIL} state_t;

  state_t           state;
  logic [31:0]      latAddr;
  logic [31:0]      latStore;
  logic             opWrite;
  logic             opAtomic;
  logic [CNT_W-1:0] svcCnt;
  logic             lastD;
  logic             linkValid;
  logic [31:0]      linkAddr;
  logic             errFlag;

  logic inService;
  logic accessNow;
  logic doneNow;
  logic dPend;
  logic linkHit;

  assign inService = (state == DSERV) || (state == ISERV);
  assign accessNow = bus.ramstate == RS_ACCESS;
  assign doneNow   = inService && (accessNow || (bus.ramstate == RS_ERROR) ||
                                   (svcCnt == CNT_W'(TIMEOUT - 1)));
  assign dPend     = bus.dREN || bus.dWEN;
  assign linkHit   = linkValid && (linkAddr == bus.daddr);
  assign bus.err   = errFlag;

  // RAM strobes and hit/data decode from the registered state and latched op
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    bus.ihit     = 1'b0;
    bus.imemload = 32'd0;
    bus.dhit     = 1'b0;
    bus.dmemload = 32'd0;
    case (state)
      DSERV: begin
        bus.ramREN  = !opWrite;
        bus.ramWEN  = opWrite;
        bus.ramaddr = latAddr;
        if (opWrite) bus.ramstore = latStore;
        if (doneNow) begin
          bus.dhit = 1'b1;
          if (accessNow) begin
            if (!opWrite)     bus.dmemload = bus.ramload;
            else if (opAtomic) bus.dmemload = 32'd1;
          end
        end
      end
      ISERV: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = latAddr;
        if (doneNow) begin
          bus.ihit = 1'b1;
          if (accessNow) bus.imemload = bus.ramload;
        end
      end
      SCFAIL:  bus.dhit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      latAddr   <= 32'd0;
      latStore  <= 32'd0;
      opWrite   <= 1'b0;
      opAtomic  <= 1'b0;
      svcCnt    <= '0;
      lastD     <= 1'b0;
      linkValid <= 1'b0;
      linkAddr  <= 32'd0;
      errFlag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          svcCnt <= '0;
          // Data wins unless fetch is also waiting and data had the last grant
          if (dPend && (!bus.iREN || !lastD)) begin
            latAddr  <= bus.daddr;
            latStore <= bus.dstore;
            opWrite  <= bus.dWEN;
            opAtomic <= bus.datomic;
            state    <= (bus.dWEN && bus.datomic && !linkHit) ? SCFAIL : DSERV;
          end else if (bus.iREN) begin
            latAddr  <= bus.iaddr;
            latStore <= 32'd0;
            opWrite  <= 1'b0;
            opAtomic <= 1'b0;
            state    <= ISERV;
          end
        end
        DSERV, ISERV: begin
          if (doneNow) begin
            state  <= IDLE;
            svcCnt <= '0;
            lastD  <= (state == DSERV);
            if (!accessNow) errFlag <= 1'b1;
            // Link tracking: LL sets, SC or any write to the linked address clears
            if (state == DSERV) begin
              if (accessNow) begin
                if (!opWrite && opAtomic) begin
                  linkValid <= 1'b1;
                  linkAddr  <= latAddr;
                end else if (opWrite && (opAtomic || (latAddr == linkAddr))) begin
                  linkValid <= 1'b0;
                end
              end else if (opWrite && opAtomic) begin
                linkValid <= 1'b0;
              end
            end
          end else begin
            svcCnt <= svcCnt + CNT_W'(1);
          end
        end
        SCFAIL: begin
          state <= IDLE;
          lastD <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM model, expected-result queues
// per requester, and immediate-assertion checks sampled on the falling edge.
module tb_ram_arbiter;
  typedef struct {
    logic        chk;
    logic [31:0] val;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ram_arbiter_if bus ();
  ram_arbiter #(.TIMEOUT(15)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  // RAM model: mode 0 ACCESS after ramDelay cycles, 1 BUSY forever, 2 ERROR
  int          ramMode;
  int unsigned ramDelay;
  int unsigned ramCnt;
  logic [31:0] memData  [0:255];
  logic        memValid [0:255];
  logic        strobe;
  logic [7:0]  memIdx;

  function automatic logic [31:0] seed(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : {16'hA5A5, a[15:0]};
  endfunction

  assign strobe = bus.ramREN | bus.ramWEN;
  assign memIdx = bus.ramaddr[9:2];

  always_comb begin
    if (!strobe)                bus.ramstate = 2'b00;
    else if (ramMode == 1)      bus.ramstate = 2'b01;
    else if (ramMode == 2)      bus.ramstate = 2'b11;
    else if (ramCnt >= ramDelay) bus.ramstate = 2'b10;
    else                        bus.ramstate = 2'b01;
  end

  always_comb bus.ramload = memValid[memIdx] ? memData[memIdx] : seed(bus.ramaddr);

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) memValid[i] <= 1'b0;
      ramCnt <= 0;
    end else begin
      ramCnt <= strobe ? ramCnt + 1 : 0;
      if (bus.ramWEN && bus.ramstate == 2'b10) begin
        memData[memIdx]  <= bus.ramstore;
        memValid[memIdx] <= 1'b1;
      end
    end
  end

  exp_t        iq[$];
  exp_t        dq[$];
  int          nPass = 0;
  int          nFail = 0;
  int          nTotal = 0;
  logic        gotI, gotD, wenSeen;
  logic [31:0] lastStore;
  int          svcCycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clrTrack();
    wenSeen = 1'b0;
    lastStore = 32'd0;
    svcCycles = 0;
  endtask

  // One falling edge: sample outputs and retire any hit against its queue
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    gotI = bus.ihit;
    gotD = bus.dhit;
    if (strobe) svcCycles++;
    if (bus.ramWEN) begin
      wenSeen = 1'b1;
      lastStore = bus.ramstore;
    end
    if (gotI) begin
      check("ihit_pending", 32'(iq.size() != 0), 32'd1);
      if (iq.size() != 0) begin
        e = iq.pop_front();
        if (e.chk) check("imemload", bus.imemload, e.val);
      end
    end
    if (gotD) begin
      check("dhit_pending", 32'(dq.size() != 0), 32'd1);
      if (dq.size() != 0) begin
        e = dq.pop_front();
        if (e.chk) check("dmemload", bus.dmemload, e.val);
      end
    end
  endtask

  task automatic waitHit(input logic isI, input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      seen = isI ? gotI : gotD;
    end
    check({tag, "_hit"}, 32'(seen), 32'd1);
    if (!seen && isI && iq.size() != 0) void'(iq.pop_front());
    if (!seen && !isI && dq.size() != 0) void'(dq.pop_front());
  endtask

  task automatic runI(input string tag, input logic [31:0] addr, input logic [31:0] expData);
    bus.iREN = 1'b1;
    bus.iaddr = addr;
    iq.push_back('{1'b1, expData});
    clrTrack();
    waitHit(1'b1, tag);
    bus.iREN = 1'b0;
    check({tag, "_wen"}, 32'(wenSeen), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(gotI), 32'd0);
  endtask

  task automatic runD(input string tag, input logic wr, input logic at, input logic [31:0] addr,
                      input logic [31:0] store, input logic chkData, input logic [31:0] expData,
                      input logic expWen);
    bus.dREN = !wr;
    bus.dWEN = wr;
    bus.datomic = at;
    bus.daddr = addr;
    bus.dstore = store;
    dq.push_back('{chkData, expData});
    clrTrack();
    waitHit(1'b0, tag);
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.datomic = 1'b0;
    check({tag, "_wen"}, 32'(wenSeen), 32'(expWen));
    if (expWen) check({tag, "_store"}, lastStore, store);
    tick();
    check({tag, "_pulse"}, 32'(gotD), 32'd0);
  endtask

  initial begin
    logic [3:0] order;
    int         nHits;
    logic       wenUp;

    RST = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.datomic = 1'b0;
    bus.daddr = 32'd0; bus.dstore = 32'd0;
    ramMode = 0;
    ramDelay = 2;
    clrTrack();
    gotI = 1'b0;
    gotD = 1'b0;
    repeat (2) tick();
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_hits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    RST = 1'b0;
    tick();

    // Fetch only, ACCESS on the third strobe cycle, then minimum latency
    runI("fetch", 32'h40, 32'hDEAD_BEEF);
    check("fetch_cycles", 32'(svcCycles), 32'd3);
    ramDelay = 0;
    runI("fetch_min", 32'h40, 32'hDEAD_BEEF);
    check("fetch_min_cycles", 32'(svcCycles), 32'd1);

    // Contention from reset: data first, then strict alternation
    ramDelay = 1;
    RST = 1'b1;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    for (int k = 0; k < 2; k++) begin
      iq.push_back('{1'b1, seed(32'h40)});
      dq.push_back('{1'b1, seed(32'h200)});
    end
    tick();
    RST = 1'b0;
    order = 4'd0;
    nHits = 0;
    for (int k = 0; k < 80 && nHits < 4; k++) begin
      tick();
      if (gotI || gotD) begin
        order = {order[2:0], gotD};
        nHits++;
      end
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    check("contention_hits", 32'(nHits), 32'd4);
    check("contention_order", 32'(order), 32'b1010);
    iq.delete();
    dq.delete();
    tick();

    // LL/SC success, then a repeated SC fails without touching RAM
    runD("ll", 1'b0, 1'b1, 32'h100, 32'd0, 1'b1, seed(32'h100), 1'b0);
    runD("sc_ok", 1'b1, 1'b1, 32'h100, 32'd5, 1'b1, 32'd1, 1'b1);
    runD("lw_after_sc", 1'b0, 1'b0, 32'h100, 32'd0, 1'b1, 32'd5, 1'b0);
    runD("sc_again", 1'b1, 1'b1, 32'h100, 32'd6, 1'b1, 32'd0, 1'b0);
    check("sc_again_cycles", 32'(svcCycles), 32'd0);

    // Plain store to the linked address breaks the link; other addresses do not
    runD("ll2", 1'b0, 1'b1, 32'h100, 32'd0, 1'b1, 32'd5, 1'b0);
    runD("sw_same", 1'b1, 1'b0, 32'h100, 32'd7, 1'b0, 32'd0, 1'b1);
    runD("sc_broken", 1'b1, 1'b1, 32'h100, 32'd8, 1'b1, 32'd0, 1'b0);
    runD("ll3", 1'b0, 1'b1, 32'h100, 32'd0, 1'b1, 32'd7, 1'b0);
    runD("sw_other", 1'b1, 1'b0, 32'h104, 32'd3, 1'b0, 32'd0, 1'b1);
    runD("sc_kept", 1'b1, 1'b1, 32'h100, 32'd9, 1'b1, 32'd1, 1'b1);

    // Timeout on a held BUSY, sticky err, then a single ERROR response
    ramMode = 1;
    runI("timeout", 32'h40, 32'd0);
    check("timeout_cycles", 32'(svcCycles), 32'd15);
    check("timeout_err", 32'(bus.err), 32'd1);
    ramMode = 0;
    runD("after_timeout", 1'b0, 1'b0, 32'h104, 32'd0, 1'b1, 32'd3, 1'b0);
    check("err_sticky", 32'(bus.err), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("err_cleared", 32'(bus.err), 32'd0);
    ramMode = 2;
    runD("ram_error", 1'b0, 1'b0, 32'h80, 32'd0, 1'b1, 32'd0, 1'b0);
    check("error_cycles", 32'(svcCycles), 32'd1);
    check("error_err", 32'(bus.err), 32'd1);
    ramMode = 0;

    // Reset during a write service: strobes drop at once and the link is lost
    runD("ll4", 1'b0, 1'b1, 32'h100, 32'd0, 1'b1, seed(32'h100), 1'b0);
    ramMode = 1;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h300;
    bus.dstore = 32'hAB;
    wenUp = 1'b0;
    for (int k = 0; k < 10 && !wenUp; k++) begin
      tick();
      wenUp = bus.ramWEN;
    end
    check("mid_wen_up", 32'(wenUp), 32'd1);
    tick();
    RST = 1'b1;
    #1;
    check("mid_rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("mid_rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("mid_rst_ramaddr", bus.ramaddr, 32'd0);
    check("mid_rst_ramstore", bus.ramstore, 32'd0);
    check("mid_rst_dhit", 32'(bus.dhit), 32'd0);
    bus.dWEN = 1'b0;
    ramMode = 0;
    tick();
    RST = 1'b0;
    runD("sc_after_rst", 1'b1, 1'b1, 32'h100, 32'h55, 1'b1, 32'd0, 1'b0);
    check("sc_after_rst_cycles", 32'(svcCycles), 32'd0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
